lab_self_test: RTL
==================

Name: lab_self_test

Overview:
- Parametrised, synthesisable self-test engine for the lab boards; replaces ad-hoc random key/sw stimulus.
- Drives the key and sw inputs of a lab top module with a repeatable LFSR pattern sequence and holds each pattern for a programmable number of cycles.
- Compresses the returned led vector into a MISR signature and flags pass/fail against an expected signature.
- Sits beside the lab top module, in simulation or on the board, clocked by the same clk.

Parameters:
- w_key, 4, key bus width
- w_sw, 4, sw bus width
- w_led, 4, led bus width
- w_sig, 16, LFSR/MISR width; w_key+w_sw <= w_sig and w_led <= w_sig
- n_steps, 8, patterns per run, >= 1
- step_cycles, 10, cycles each pattern is held, >= 1
- lfsr_seed, 16'hACE1, LFSR reload value, non-zero
- lfsr_taps, 16'hB400, Galois tap mask (x^16+x^14+x^13+x^11+1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle run request
- abort  in  1  synchronous run cancel
- expected_sig  in  w_sig  golden signature
- led_in  in  w_led  led vector returned by the DUT
- key_out  out  w_key  stimulus to DUT key
- sw_out  out  w_sw  stimulus to DUT sw
- busy  out  1  run in progress
- done  out  1  run completed; level
- pass  out  1  signature == expected_sig; valid while done=1
- signature  out  w_sig  current MISR value
- step_idx  out  max(1,$clog2(n_steps))  index of the current pattern

Behaviour:
- Reset (rst=0, async): state IDLE; lfsr=lfsr_seed; misr=0; cnt=0; step_idx=0; key_out=0, sw_out=0; busy=done=pass=0.
- LFSR advance: if lfsr[0], lfsr=(lfsr>>1)^lfsr_taps; else lfsr=lfsr>>1.
- Pattern mapping: key_out=lfsr[w_key-1:0]; sw_out=lfsr[w_key+w_sw-1:w_key].
- MISR capture: apply the same shift/tap rule to misr, then XOR with zero-extended led_in.
- FSM states: IDLE, DRIVE, DONE.
- IDLE/DONE + start=1 at edge:
  - lfsr reloads to seed and advances once in the same edge, so the first pattern is always advance(seed).
  - misr=0, done=0, pass=0, cnt=0, step_idx=0, busy=1.
  - key_out/sw_out show the new pattern from the next cycle. Go to DRIVE.
- DRIVE, cnt<step_cycles-1: cnt++, outputs held.
- DRIVE, cnt==step_cycles-1:
  - MISR captures led_in.
  - If step_idx==n_steps-1: go to DONE, busy=0, done=1, pass=(misr_next==expected_sig), key_out=sw_out=0.
  - Otherwise: step_idx++, cnt=0, LFSR advances, outputs update.
- Each pattern is held exactly step_cycles cycles. Total run = n_steps*step_cycles cycles from the start edge to the done edge.
- start while busy: ignored.
- abort=1 in DRIVE: next edge goes to IDLE, busy=0, done=0, pass=0, outputs=0; signature keeps its partial value. abort has priority over capture and completion in the same cycle. abort in IDLE/DONE: no effect.
- start and abort both high in IDLE/DONE: start wins.
- done, pass and signature hold in DONE until the next start or reset.
- Reset asserted mid-run: immediate return to reset values; no partial done.
- signature mirrors misr continuously.

Test Plan:
- Defaults, led_in=0, start pulse:
  - key/sw sequence begins (0,7), (8,3), (C,9), each held 10 cycles.
  - done rises exactly 80 cycles after the start edge; signature=0.
  - expected_sig=0 gives pass=1; expected_sig=1 gives pass=0.
- n_steps=2, step_cycles=1, led_in=4'h1 constant -> signature 0x0001 after step 0, 0xB401 at done.
- abort asserted at cycle 25 of a default run -> busy=0, done=0, outputs 0 the next cycle; a following start gives an identical sequence starting (0,7).
- start pulsed again at cycles 5 and 40 of a running default run -> ignored; done still at cycle 80; step_idx ran 0..7 monotonically.
- rst driven low mid-DRIVE, between clock edges -> outputs 0 and busy 0 immediately, not at the next edge; after release, a start reproduces the first pattern (0,7).
- Back-to-back runs: start in DONE with identical led_in -> same signature and pass as the first run; done drops on the start edge.

Source files
------------

// File: rtl/lab_self_test.sv
// ---------------------------------------------------------------------------
// lab_self_test
//
// Self-test engine for the lab boards. It drives the key/sw inputs of a lab
// top module with a repeatable LFSR pattern sequence. Each pattern is held for
// step_cycles cycles. At the end of every pattern the returned led vector is
// folded into a MISR signature. After n_steps patterns the signature is
// compared against a golden value, and the result is reported on pass.
//
// Ports:
//   clk          in   1       system clock
//   rst          in   1       asynchronous reset, active-low
//   start        in   1       one-cycle run request (accepted in IDLE/DONE)
//   abort        in   1       synchronous run cancel (acts in DRIVE only)
//   expected_sig in   w_sig   golden signature
//   led_in       in   w_led   led vector returned by the board design
//   key_out      out  w_key   stimulus to the board key input
//   sw_out       out  w_sw    stimulus to the board sw input
//   busy         out  1       run in progress
//   done         out  1       run completed (level, held until next start)
//   pass         out  1       signature == expected_sig, valid while done=1
//   signature    out  w_sig   current MISR value
//   step_idx     out  idx     index of the pattern currently driven
// ---------------------------------------------------------------------------
module lab_self_test #(
  parameter int               w_key       = 4,
  parameter int               w_sw        = 4,
  parameter int               w_led       = 4,
  parameter int               w_sig       = 16,
  parameter int               n_steps     = 8,
  parameter int               step_cycles = 10,
  parameter logic [w_sig-1:0] lfsr_seed   = 16'hACE1,
  parameter logic [w_sig-1:0] lfsr_taps   = 16'hB400
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic [w_sig-1:0]                              expected_sig,
  input  logic [w_led-1:0]                              led_in,
  output logic [w_key-1:0]                              key_out,
  output logic [w_sw-1:0]                               sw_out,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          pass,
  output logic [w_sig-1:0]                              signature,
  output logic [((n_steps > 1) ? $clog2(n_steps) : 1)-1:0] step_idx
);

  localparam int w_idx = (n_steps > 1) ? $clog2(n_steps) : 1;
  localparam int w_cnt = (step_cycles > 1) ? $clog2(step_cycles) : 1;

  localparam logic [w_idx-1:0] idx_last = w_idx'(n_steps - 1);
  localparam logic [w_cnt-1:0] cnt_last = w_cnt'(step_cycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [w_sig-1:0]   lfsr_reg;
  logic [w_sig-1:0]   misr_reg;
  logic [w_cnt-1:0]   cnt_reg;
  logic [w_idx-1:0]   step_reg;

  logic [w_sig-1:0]   lfsr_adv;
  logic [w_sig-1:0]   seed_adv;
  logic [w_sig-1:0]   misr_next;
  logic [w_sig-1:0]   led_ext;

  // Galois shift: shift right, fold the taps in when the bit shifted out was 1.
  // LFSR and MISR share this rule.
  function automatic logic [w_sig-1:0] galois_step(input logic [w_sig-1:0] v);
    if (v[0]) begin
      return (v >> 1) ^ lfsr_taps;
    end
    return v >> 1;
  endfunction

  // Zero-extend led_in to the signature width.
  for (genvar gi = 0; gi < w_sig; gi++) begin : g_led_ext
    if (gi < w_led) begin : g_bit
      assign led_ext[gi] = led_in[gi];
    end else begin : g_zero
      assign led_ext[gi] = 1'b0;
    end
  end

  // The first pattern of every run is advance(seed). It is a constant, so a
  // restart never depends on where the previous run left the LFSR.
  assign seed_adv  = galois_step(lfsr_seed);
  assign lfsr_adv  = galois_step(lfsr_reg);
  assign misr_next = galois_step(misr_reg) ^ led_ext;

  assign signature = misr_reg;
  assign step_idx  = step_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      lfsr_reg  <= lfsr_seed;
      misr_reg  <= '0;
      cnt_reg   <= '0;
      step_reg  <= '0;
      key_out   <= '0;
      sw_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // start wins over a simultaneous abort here. abort alone does nothing.
          if (start) begin
            state_reg <= DRIVE;
            lfsr_reg  <= seed_adv;
            misr_reg  <= '0;
            cnt_reg   <= '0;
            step_reg  <= '0;
            key_out   <= seed_adv[w_key-1:0];
            sw_out    <= seed_adv[w_key+w_sw-1:w_key];
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end

        DRIVE: begin
          if (abort) begin
            // Cancel outranks capture and completion. The partial signature
            // stays visible for debugging.
            state_reg <= IDLE;
            cnt_reg   <= '0;
            key_out   <= '0;
            sw_out    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
          end else if (cnt_reg == cnt_last) begin
            // Last cycle of this pattern: sample led_in into the signature.
            misr_reg <= misr_next;
            if (step_reg == idx_last) begin
              state_reg <= DONE;
              key_out   <= '0;
              sw_out    <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (misr_next == expected_sig);
            end else begin
              step_reg <= step_reg + 1'b1;
              cnt_reg  <= '0;
              lfsr_reg <= lfsr_adv;
              key_out  <= lfsr_adv[w_key-1:0];
              sw_out   <= lfsr_adv[w_key+w_sw-1:w_key];
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
